// File: rtl/traffic_time_setter.sv
// traffic_time_setter: debounced four-key editor for the green/yellow/red BCD
// countdown durations. Sel enters edit mode and steps through the fields, up/down
// edit the shown value, and ok commits all three and offers them over cfg_valid/cfg_ready.
// Build option: define TIME_SET_TIMEOUT_EN to abandon an edit after TIMEOUT_CNT idle cycles.

module tts_key_cond #(
    parameter logic [31:0] DEB_CNT = 32'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);
    logic        sync1_q;
    logic        sync2_q;
    logic        lvl_q;
    logic        lvl_dly_q;
    logic [31:0] cnt_q;

    // Synchronise the raw key; a new level is accepted after DEB_CNT+1 disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl_q;
            if (sync2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= DEB_CNT) begin
                lvl_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // One-cycle pulse in the cycle after the debounced level rises; releases are silent.
    assign press_o = lvl_q & ~lvl_dly_q;
endmodule

module traffic_time_setter #(
    parameter logic [31:0] DEB_CNT    = 32'd1,
    parameter logic [7:0]  DEF_GREEN  = 8'h60,
    parameter logic [7:0]  DEF_YELLOW = 8'h04,
    parameter logic [7:0]  DEF_RED    = 8'h20
`ifdef TIME_SET_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CNT = 32'd100
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_ok,
    input  logic       cfg_ready,
    output logic       cfg_valid,
    output logic [7:0] green_t,
    output logic [7:0] yellow_t,
    output logic [7:0] red_t,
    output logic [7:0] edit_val,
    output logic [1:0] edit_idx,
    output logic       editing
);
    localparam int K_SEL = 0;
    localparam int K_UP  = 1;
    localparam int K_DN  = 2;
    localparam int K_OK  = 3;

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_SEND} state_e;

    logic [3:0]      key_raw;
    logic [3:0]      press;
    state_e          state_q, state_d;
    logic [2:0][7:0] shadow_q, shadow_d;   // [0]=green [1]=yellow [2]=red
    logic [2:0][7:0] commit_q, commit_d;
    logic [2:0][7:0] shadow_wr;            // shadow with the value under edit folded in
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      idx_cur, idx_nxt;
    logic [7:0]      val_q, val_d;
`ifdef TIME_SET_TIMEOUT_EN
    logic [31:0]     to_cnt_q, to_cnt_d;
`endif

    assign key_raw = {key_ok, key_down, key_up, key_sel};

    for (genvar k = 0; k < 4; k++) begin : g_key
        tts_key_cond #(.DEB_CNT(DEB_CNT)) u_key (
            .clk     (clk),
            .rst     (rst),
            .key_i   (key_raw[k]),
            .press_o (press[k])
        );
    end

    // Index 3 cannot be reached legally; treat it as green if it ever shows up.
    assign idx_cur = (idx_q == 2'd3) ? 2'd0 : idx_q;
    assign idx_nxt = (idx_cur == 2'd2) ? 2'd0 : idx_cur + 2'd1;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)          r = 8'h01;
        else if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'h0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v <= 8'h01)          r = 8'h99;
        else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'h9};
        else                     r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // State and data registers; reset restores the default durations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= {DEF_RED, DEF_YELLOW, DEF_GREEN};
            commit_q <= {DEF_RED, DEF_YELLOW, DEF_GREEN};
            idx_q    <= 2'd0;
            val_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            commit_q <= commit_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
        end
    end

`ifdef TIME_SET_TIMEOUT_EN
    // Idle-cycle counter for abandoning an untouched edit.
    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`endif

    // Next-state: IDLE waits for sel, EDIT takes one key per cycle (ok > sel > up > down), SEND waits for ready.
    always_comb begin
        state_d            = state_q;
        shadow_d           = shadow_q;
        commit_d           = commit_q;
        idx_d              = idx_cur;
        val_d              = val_q;
        shadow_wr          = shadow_q;
        shadow_wr[idx_cur] = val_q;
`ifdef TIME_SET_TIMEOUT_EN
        to_cnt_d           = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press[K_SEL]) begin
                    shadow_d = commit_q;
                    idx_d    = 2'd0;
                    val_d    = commit_q[0];
                    state_d  = S_EDIT;
`ifdef TIME_SET_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_EDIT: begin
                if (press[K_OK]) begin
                    shadow_d = shadow_wr;
                    commit_d = shadow_wr;
                    state_d  = S_SEND;
`ifdef TIME_SET_TIMEOUT_EN
                end else if (to_cnt_q == TIMEOUT_CNT) begin
                    state_d  = S_IDLE;
`endif
                end else begin
                    if (press[K_SEL]) begin
                        shadow_d = shadow_wr;
                        idx_d    = idx_nxt;
                        val_d    = shadow_q[idx_nxt];
                    end else if (press[K_UP]) begin
                        val_d = bcd_inc(val_q);
                    end else if (press[K_DN]) begin
                        val_d = bcd_dec(val_q);
                    end
`ifdef TIME_SET_TIMEOUT_EN
                    to_cnt_d = (|press) ? '0 : to_cnt_q + 32'd1;
`endif
                end
            end
            S_SEND: begin
                if (cfg_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_valid = (state_q == S_SEND);
    assign editing   = (state_q == S_EDIT);
    assign edit_idx  = idx_cur;
    assign edit_val  = val_q;
    assign green_t   = commit_q[0];
    assign yellow_t  = commit_q[1];
    assign red_t     = commit_q[2];
endmodule

// File: tb/tb_traffic_time_setter.sv
// Bench for traffic_time_setter: a decimal-arithmetic model of the editor runs
// alongside the DUT and every output is compared each cycle, plus literal checks
// on the values the directed sequences must produce.
module tb_traffic_time_setter;
    localparam int DEB    = 1;
    localparam int TOC    = 100;
    localparam int M_IDLE = 0;
    localparam int M_EDIT = 1;
    localparam int M_SEND = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_ready = 1'b0;
    logic [3:0] keys = 4'b0000;   // 0 sel, 1 up, 2 down, 3 ok
    logic       cfg_valid, editing;
    logic [7:0] green_t, yellow_t, red_t, edit_val;
    logic [1:0] edit_idx;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cv_cnt = 0;
    int ed_rises = 0;
    logic ed_prev = 1'b0;

    traffic_time_setter dut (
        .clk(clk), .rst(rst),
        .key_sel(keys[0]), .key_up(keys[1]), .key_down(keys[2]), .key_ok(keys[3]),
        .cfg_ready(cfg_ready), .cfg_valid(cfg_valid),
        .green_t(green_t), .yellow_t(yellow_t), .red_t(red_t),
        .edit_val(edit_val), .edit_idx(edit_idx), .editing(editing)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic           m_on = 1'b0;
    int             m_mode, m_idx, m_idle;
    logic [7:0]     m_com [3];
    logic [7:0]     m_sh  [3];
    logic [7:0]     m_val;
    logic [DEB+2:0] hq [4];        // hq[k][j] = raw key k sampled j edges ago
    logic [3:0]     lvl, rise, p;
    logic           all_diff;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input int dir);
        int d;
        d = int'(v[7:4]) * 10 + int'(v[3:0]) + dir;
        if (d > 99) d = 1;
        if (d < 1)  d = 99;
        return 8'((d / 10) * 16 + d % 10);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on   = 1'b1;
            m_mode = M_IDLE;
            m_com[0] = 8'h60; m_com[1] = 8'h04; m_com[2] = 8'h20;
            m_sh   = m_com;
            m_idx  = 0;
            m_val  = 8'h00;
            m_idle = 0;
            for (int k = 0; k < 4; k++) hq[k] = '0;
            lvl  = '0;
            rise = '0;
        end else begin
            p = rise;
            case (m_mode)
                M_IDLE: if (p[0]) begin
                    m_sh = m_com; m_idx = 0; m_val = m_com[0]; m_mode = M_EDIT; m_idle = 0;
                end
                M_EDIT: begin
                    if (p[3]) begin
                        m_sh[m_idx] = m_val; m_com = m_sh; m_mode = M_SEND;
`ifdef TIME_SET_TIMEOUT_EN
                    end else if (m_idle == TOC) begin
                        m_mode = M_IDLE;
`endif
                    end else begin
                        if (p[0]) begin
                            m_sh[m_idx] = m_val; m_idx = (m_idx + 1) % 3; m_val = m_sh[m_idx];
                        end else if (p[1]) m_val = bcd_step(m_val, 1);
                        else if (p[2])     m_val = bcd_step(m_val, -1);
                        m_idle = (p != 4'b0000) ? 0 : m_idle + 1;
                    end
                end
                default: if (cfg_ready) m_mode = M_IDLE;
            endcase
            // A key level is taken once the last DEB+1 synchronised samples all disagree with it.
            for (int k = 0; k < 4; k++) begin
                hq[k] = {hq[k][DEB+1:0], keys[k]};
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 2; j++) if (hq[k][j] == lvl[k]) all_diff = 1'b0;
                rise[k] = 1'b0;
                if (all_diff) begin
                    lvl[k]  = ~lvl[k];
                    rise[k] = lvl[k];
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance n cycles, comparing every output with the model at each falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (m_on) begin
                check("cyc_cfg_valid", 32'(cfg_valid), 32'(m_mode == M_SEND));
                check("cyc_editing",   32'(editing),   32'(m_mode == M_EDIT));
                check("cyc_green",     32'(green_t),   32'(m_com[0]));
                check("cyc_yellow",    32'(yellow_t),  32'(m_com[1]));
                check("cyc_red",       32'(red_t),     32'(m_com[2]));
                check("cyc_edit_val",  32'(edit_val),  32'(m_val));
                check("cyc_edit_idx",  32'(edit_idx),  32'(m_idx));
                if (cfg_valid) cv_cnt++;
                if (editing && !ed_prev) ed_rises++;
                ed_prev = editing;
            end
        end
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        keys = m;
        cyc(hold);
        keys = 4'b0000;
        cyc(7);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    int   r0, cv0;
    logic seen99;

    initial begin
        // reset
        cyc(2);
        rst = 1'b0;
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_green",     32'(green_t),   32'h60);
        check("rst_yellow",    32'(yellow_t),  32'h04);
        check("rst_red",       32'(red_t),     32'h20);
        check("rst_editing",   32'(editing),   32'd0);
        check("rst_edit_val",  32'(edit_val),  32'h00);

        // one-cycle glitch is filtered
        keys = 4'b0001; cyc(1); keys = 4'b0000; cyc(8);
        check("glitch_editing", 32'(editing), 32'd0);

        // long sel -> one entry into EDIT
        r0 = ed_rises;
        press(4'b0001, 10);
        check("sel_entries",  32'(ed_rises - r0), 32'd1);
        check("sel_editing",  32'(editing),  32'd1);
        check("sel_edit_val", 32'(edit_val), 32'h60);
        check("sel_edit_idx", 32'(edit_idx), 32'd0);

        // 40 ups from 60: through 99, wrap to 01
        seen99 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            press(4'b0010, 3);
            if (edit_val == 8'h99) seen99 = 1'b1;
        end
        check("up_seen99", 32'(seen99),   32'd1);
        check("up_wrap01", 32'(edit_val), 32'h01);
        for (int i = 0; i < 9; i++) press(4'b0010, 3);
        check("up_to10",   32'(edit_val), 32'h10);
        press(4'b0100, 3);
        check("down_09",   32'(edit_val), 32'h09);
        press(4'b0100, 3); press(4'b0100, 3); press(4'b0100, 3);
        press(4'b0100, 3); press(4'b0100, 3); press(4'b0100, 3);
        press(4'b0100, 3); press(4'b0100, 3);
        check("down_01",   32'(edit_val), 32'h01);
        press(4'b0100, 3);
        check("down_wrap99", 32'(edit_val), 32'h99);

        // reset mid-edit aborts
        do_reset();
        check("rst2_editing", 32'(editing), 32'd0);
        check("rst2_green",   32'(green_t), 32'h60);

        // full edit of all three fields, slow ready
        press(4'b0001, 3);
        press(4'b0010, 3);
        press(4'b0001, 3);
        check("seq_idx1", 32'(edit_idx), 32'd1);
        check("seq_val_y", 32'(edit_val), 32'h04);
        press(4'b0100, 3);
        press(4'b0001, 3);
        check("seq_idx2", 32'(edit_idx), 32'd2);
        press(4'b0010, 3);
        press(4'b1000, 3);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("send_hold_valid", 32'(cfg_valid), 32'd1);
        end
        cfg_ready = 1'b1; cyc(1); cfg_ready = 1'b0; cyc(1);
        check("send_drop_valid", 32'(cfg_valid), 32'd0);
        check("seq_green",  32'(green_t),  32'h61);
        check("seq_yellow", 32'(yellow_t), 32'h03);
        check("seq_red",    32'(red_t),    32'h21);

        // ok beats a simultaneous up; keys in SEND are dropped
        press(4'b0001, 3);
        check("ok_enter_val", 32'(edit_val), 32'h61);
        press(4'b0010, 3);
        press(4'b1010, 3);
        check("okwin_valid", 32'(cfg_valid), 32'd1);
        check("okwin_green", 32'(green_t),   32'h62);
        press(4'b0010, 3);
        press(4'b0001, 3);
        check("sendkeys_valid",   32'(cfg_valid), 32'd1);
        check("sendkeys_editing", 32'(editing),   32'd0);
        check("sendkeys_val",     32'(edit_val),  32'h62);
        cfg_ready = 1'b1; cyc(1); cfg_ready = 1'b0; cyc(2);
        check("okwin_idle", 32'(cfg_valid), 32'd0);

        // idle-edit behaviour
        do_reset();
        cv0 = cv_cnt;
        press(4'b0001, 3);
        press(4'b0010, 3);
        press(4'b0010, 3);
        cyc(80);
        check("idle80_editing", 32'(editing), 32'd1);
        cyc(40);
`ifdef TIME_SET_TIMEOUT_EN
        check("timeout_editing", 32'(editing), 32'd0);
        check("timeout_green",   32'(green_t), 32'h60);
`else
        check("persist_editing", 32'(editing),  32'd1);
        check("persist_val",     32'(edit_val), 32'h62);
        do_reset();
`endif
        check("timeout_no_valid", 32'(cv_cnt - cv0), 32'd0);

        // ok in IDLE does nothing
        press(4'b1000, 3);
        check("idle_ok_valid", 32'(cfg_valid), 32'd0);
        check("idle_ok_green", 32'(green_t),   32'h60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
